proc_run_ctrl: RTL and testbench

//  Synthesizable run controller for the RISC-V processor: streams a program into

---
 rtl/proc_run_ctrl.sv | 145 ++++++++++++++
 tb/tb_proc_run_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/proc_run_ctrl.sv
// Run controller for the RISC-V core: loads IMEM over a valid/ready stream,
// holds the core in reset, runs it, and stops on a tohost store or a timeout.
module proc_run_ctrl #(
    parameter int              DATA_W      = 32,
    parameter int              ADDR_W      = 32,
    parameter int              IMEM_DEPTH  = 256,
    parameter int              MAX_CYCLES  = 1000,
    parameter logic [31:0]     TOHOST_ADDR = 32'h0000_0FFC,
    parameter int              RST_HOLD    = 2,
    localparam int             IA_W        = $clog2(IMEM_DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    output logic              imem_we,
    output logic [IA_W-1:0]   imem_addr,
    output logic [DATA_W-1:0] imem_wdata,
    output logic              core_rst,
    input  logic              dmem_we,
    input  logic [ADDR_W-1:0] dmem_addr,
    input  logic [DATA_W-1:0] dmem_wdata,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              timeout,
    output logic              load_ovf,
    output logic [DATA_W-1:0] exit_code,
    output logic [31:0]       cycle_count
);

    localparam int              HC_W    = $clog2(RST_HOLD + 1);
    localparam logic [IA_W-1:0] PTR_MAX = IA_W'(IMEM_DEPTH - 1);
    localparam logic [HC_W-1:0] HC_LAST = HC_W'(RST_HOLD - 1);
    localparam logic [ADDR_W-1:0] TOHOST = ADDR_W'(TOHOST_ADDR);
    localparam logic [31:0]     CYC_MAX = 32'(MAX_CYCLES);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        HOLD = 3'd2,
        RUN  = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t          state_r;
    logic [IA_W-1:0] ptr_r;
    logic [HC_W-1:0] hold_cnt_r;
    logic            tohost_hit_s;
    logic [31:0]     cycle_next_s;

    assign ld_ready     = (state_r == LOAD);
    assign tohost_hit_s = dmem_we && (dmem_addr == TOHOST);
    assign cycle_next_s = cycle_count + 32'd1;

    // Controller FSM; every output except ld_ready is registered here.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r     <= IDLE;
            ptr_r       <= '0;
            hold_cnt_r  <= '0;
            imem_we     <= 1'b0;
            imem_addr   <= '0;
            imem_wdata  <= '0;
            core_rst    <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            timeout     <= 1'b0;
            load_ovf    <= 1'b0;
            exit_code   <= '0;
            cycle_count <= 32'd0;
        end else begin
            imem_we <= 1'b0;
            case (state_r)
                IDLE, DONE: begin
                    if (start) begin
                        state_r   <= LOAD;
                        ptr_r     <= '0;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        pass      <= 1'b0;
                        timeout   <= 1'b0;
                        load_ovf  <= 1'b0;
                        exit_code <= '0;
                    end
                end
                LOAD: begin
                    if (ld_valid) begin
                        imem_we    <= 1'b1;
                        imem_addr  <= ptr_r;
                        imem_wdata <= ld_data;
                        // Pointer saturates at the last word so it never wraps.
                        if (ptr_r != PTR_MAX) begin
                            ptr_r <= ptr_r + {{(IA_W-1){1'b0}}, 1'b1};
                        end
                        if (ld_last || (ptr_r == PTR_MAX)) begin
                            state_r     <= HOLD;
                            hold_cnt_r  <= '0;
                            cycle_count <= 32'd0;
                            load_ovf    <= !ld_last;
                        end
                    end
                end
                HOLD: begin
                    if (hold_cnt_r == HC_LAST) begin
                        state_r  <= RUN;
                        core_rst <= 1'b0;
                    end else begin
                        hold_cnt_r <= hold_cnt_r + {{(HC_W-1){1'b0}}, 1'b1};
                    end
                end
                RUN: begin
                    cycle_count <= cycle_next_s;
                    // A tohost store in the final cycle takes priority over timeout.
                    if (tohost_hit_s) begin
                        state_r   <= DONE;
                        core_rst  <= 1'b1;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        exit_code <= dmem_wdata;
                        pass      <= (dmem_wdata == DATA_W'(1));
                        timeout   <= 1'b0;
                    end else if (cycle_next_s == CYC_MAX) begin
                        state_r  <= DONE;
                        core_rst <= 1'b1;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        pass     <= 1'b0;
                        timeout  <= 1'b1;
                    end
                end
                default: begin
                    state_r  <= IDLE;
                    core_rst <= 1'b1;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_proc_run_ctrl.sv
// Directed self-checking bench for proc_run_ctrl (small IMEM, short timeout).
module tb_proc_run_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        ld_valid;
    logic        ld_ready;
    logic [31:0] ld_data;
    logic        ld_last;
    logic        imem_we;
    logic [2:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        core_rst;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        busy;
    logic        done;
    logic        pass;
    logic        timeout;
    logic        load_ovf;
    logic [31:0] exit_code;
    logic [31:0] cycle_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    proc_run_ctrl #(
        .DATA_W(32), .ADDR_W(32), .IMEM_DEPTH(8), .MAX_CYCLES(50),
        .TOHOST_ADDR(32'h0000_0FFC), .RST_HOLD(2)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data), .ld_last(ld_last),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .core_rst(core_rst),
        .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .busy(busy), .done(done), .pass(pass), .timeout(timeout), .load_ovf(load_ovf),
        .exit_code(exit_code), .cycle_count(cycle_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Start from IDLE/DONE, then idle until the controller reaches RUN cycle 1.
    task automatic load_one_and_run();
        start = 1'b1; tick(); start = 1'b0;
        ld_valid = 1'b1; ld_data = 32'h0000_0013; ld_last = 1'b1; tick();
        ld_valid = 1'b0; ld_last = 1'b0;
        tick(); tick();
    endtask

    int gaps [3] = '{1, 3, 2};

    initial begin
        rst = 1'b0; start = 1'b0; ld_valid = 1'b0; ld_data = 32'd0; ld_last = 1'b0;
        dmem_we = 1'b0; dmem_addr = 32'd0; dmem_wdata = 32'd0;
        tick(); tick();
        chk("rst_core_rst", 32'(core_rst), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_ld_ready", 32'(ld_ready), 32'd0);
        chk("rst_imem_we", 32'(imem_we), 32'd0);
        chk("rst_cycles", cycle_count, 32'd0);
        rst = 1'b1;
        tick();

        // 4-word program, continuous valid
        start = 1'b1; tick(); start = 1'b0;
        chk("ld_busy", 32'(busy), 32'd1);
        chk("ld_ready", 32'(ld_ready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            ld_valid = 1'b1; ld_data = 32'hA000_0000 + 32'(i); ld_last = (i == 3);
            tick();
            chk("ld4_we", 32'(imem_we), 32'd1);
            chk("ld4_addr", 32'(imem_addr), 32'(i));
            chk("ld4_data", imem_wdata, 32'hA000_0000 + 32'(i));
        end
        ld_valid = 1'b0; ld_last = 1'b0;
        chk("hold1_core_rst", 32'(core_rst), 32'd1);
        chk("hold1_ready", 32'(ld_ready), 32'd0);
        tick();
        chk("hold2_core_rst", 32'(core_rst), 32'd1);
        chk("hold2_we", 32'(imem_we), 32'd0);
        chk("hold2_busy", 32'(busy), 32'd1);
        tick();
        chk("run_core_rst", 32'(core_rst), 32'd0);
        chk("run_busy", 32'(busy), 32'd1);
        chk("run_cyc0", cycle_count, 32'd0);

        // RUN cycles 1..19: non-tohost stores and a stray start are ignored
        dmem_we = 1'b1; dmem_addr = 32'h0000_0FF8; dmem_wdata = 32'd1; start = 1'b1;
        for (int i = 0; i < 19; i++) tick();
        start = 1'b0;
        chk("ff8_done", 32'(done), 32'd0);
        chk("ff8_cyc", cycle_count, 32'd19);
        chk("start_ign_ready", 32'(ld_ready), 32'd0);
        dmem_addr = 32'h0000_0FFC; dmem_wdata = 32'd1;
        tick();
        dmem_we = 1'b0;
        chk("pass_done", 32'(done), 32'd1);
        chk("pass_pass", 32'(pass), 32'd1);
        chk("pass_exit", exit_code, 32'd1);
        chk("pass_cyc", cycle_count, 32'd20);
        chk("pass_timeout", 32'(timeout), 32'd0);
        chk("pass_busy", 32'(busy), 32'd0);
        chk("pass_core_rst", 32'(core_rst), 32'd1);
        tick(); tick();
        chk("done_held", 32'(done), 32'd1);
        chk("cyc_held", cycle_count, 32'd20);

        // Reload with valid gaps, then exit code 7
        start = 1'b1; tick(); start = 1'b0;
        chk("restart_done", 32'(done), 32'd0);
        chk("restart_exit", exit_code, 32'd0);
        for (int k = 0; k < 3; k++) begin
            ld_valid = 1'b0;
            for (int g = 0; g < gaps[k]; g++) begin
                tick();
                chk("gap_we", 32'(imem_we), 32'd0);
            end
            ld_valid = 1'b1; ld_data = 32'hB000_0000 + 32'(k); ld_last = (k == 2);
            tick();
            chk("gap_acc_we", 32'(imem_we), 32'd1);
            chk("gap_addr", 32'(imem_addr), 32'(k));
            chk("gap_data", imem_wdata, 32'hB000_0000 + 32'(k));
        end
        ld_valid = 1'b0; ld_last = 1'b0;
        tick(); tick();
        chk("gap_run", 32'(core_rst), 32'd0);
        tick(); tick();
        dmem_we = 1'b1; dmem_addr = 32'h0000_0FFC; dmem_wdata = 32'd7;
        tick();
        dmem_we = 1'b0;
        chk("fail_done", 32'(done), 32'd1);
        chk("fail_pass", 32'(pass), 32'd0);
        chk("fail_exit", exit_code, 32'd7);
        chk("fail_timeout", 32'(timeout), 32'd0);
        chk("fail_cyc", cycle_count, 32'd3);

        // Timeout at 50 cycles
        load_one_and_run();
        for (int i = 0; i < 49; i++) tick();
        chk("to_pre_done", 32'(done), 32'd0);
        chk("to_pre_cyc", cycle_count, 32'd49);
        tick();
        chk("to_done", 32'(done), 32'd1);
        chk("to_timeout", 32'(timeout), 32'd1);
        chk("to_pass", 32'(pass), 32'd0);
        chk("to_cyc", cycle_count, 32'd50);
        chk("to_exit", exit_code, 32'd0);

        // Tohost store in the timeout cycle wins
        load_one_and_run();
        chk("reload_timeout_clr", 32'(timeout), 32'd0);
        for (int i = 0; i < 49; i++) tick();
        dmem_we = 1'b1; dmem_addr = 32'h0000_0FFC; dmem_wdata = 32'd1;
        tick();
        dmem_we = 1'b0;
        chk("race_done", 32'(done), 32'd1);
        chk("race_timeout", 32'(timeout), 32'd0);
        chk("race_pass", 32'(pass), 32'd1);
        chk("race_cyc", cycle_count, 32'd50);

        // IMEM overflow: 10 words into 8 entries
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            ld_valid = 1'b1; ld_data = 32'hC000_0000 + 32'(i); ld_last = (i == 9);
            tick();
            if (i < 8) begin
                chk("ovf_we", 32'(imem_we), 32'd1);
                chk("ovf_addr", 32'(imem_addr), 32'(i));
            end else begin
                chk("ovf_nowrite", 32'(imem_we), 32'd0);
            end
        end
        ld_valid = 1'b0; ld_last = 1'b0;
        chk("ovf_flag", 32'(load_ovf), 32'd1);
        chk("ovf_run", 32'(core_rst), 32'd0);
        for (int i = 0; i < 5; i++) tick();

        // Reset mid-RUN
        rst = 1'b0; tick();
        chk("mid_rst_core_rst", 32'(core_rst), 32'd1);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_ovf", 32'(load_ovf), 32'd0);
        chk("mid_rst_cyc", cycle_count, 32'd0);
        rst = 1'b1; tick();
        chk("post_rst_idle", 32'(ld_ready), 32'd0);
        chk("post_rst_core_rst", 32'(core_rst), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
